// File: rtl/hazard_control_unit.sv
// Hazard control for a 5-stage RISC-V pipeline.
// Forwarding, load-use stalls, redirects and a debug halt/step FSM.
module hazard_control_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic [1:0]  ResultSrcE,
  input  logic        PCSrcE,
  input  logic        DbgHalt,
  input  logic        DbgStep,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic        FlushE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        HaltedAck,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2,
    STEP   = 2'd3
  } state_t;

  state_t      state_q;
  logic [1:0]  drain_q;
  logic        halted_q;
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;
  logic        lw_stall;
  logic        run_like;

  assign lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0)
                 && ((RdE == Rs1D) || (RdE == Rs2D));
  assign run_like = (state_q == RUN) || (state_q == STEP);

  // Operand forwarding; memory stage has priority over writeback
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (!rst) begin
      if (RegWriteM && RdM != 5'd0 && RdM == Rs1E)
        ForwardAE = 2'b10;
      else if (RegWriteW && RdW != 5'd0 && RdW == Rs1E)
        ForwardAE = 2'b01;
      if (RegWriteM && RdM != 5'd0 && RdM == Rs2E)
        ForwardBE = 2'b10;
      else if (RegWriteW && RdW != 5'd0 && RdW == Rs2E)
        ForwardBE = 2'b01;
    end
  end

  // Stall/flush steering; halted states hold F/D unless redirected
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (!rst) begin
      if (run_like) begin
        StallF = lw_stall;
        StallD = lw_stall;
        FlushD = PCSrcE;
        FlushE = lw_stall | PCSrcE;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  assign HaltedAck  = halted_q & ~rst;
  assign StallCount = rst ? 32'd0 : stall_cnt_q;
  assign FlushCount = rst ? 32'd0 : flush_cnt_q;

  // Debug FSM, drain counter, registered halt ack and event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      drain_q     <= 2'd0;
      halted_q    <= 1'b0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (DbgHalt) begin
            state_q <= DRAIN;
            drain_q <= 2'd3;
          end
        end
        DRAIN: begin
          if (drain_q == 2'd1) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
            drain_q  <= 2'd0;
          end else begin
            drain_q <= drain_q - 2'd1;
          end
        end
        HALTED: begin
          if (!DbgHalt) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
          end else if (DbgStep) begin
            state_q  <= STEP;
            halted_q <= 1'b0;
          end
        end
        STEP: begin
          if (!lw_stall) begin
            state_q <= DRAIN;
            drain_q <= 2'd3;
          end
        end
      endcase
      if (run_like && lw_stall)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (PCSrcE)
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 The block SHALL have these ports: clk input 1 (pipeline clock); rst input 1 (synchronous, active-high reset, sampled on rising clk).
REQ-002 The block SHALL have these register-address inputs: Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, each 5 bits, from the decode, execute, memory and writeback stages.
REQ-003 The block SHALL have these stage control inputs: RegWriteM 1, RegWriteW 1, ResultSrcE 2 (2'b01 = load), PCSrcE 1 (taken branch or jump in execute).
REQ-004 The block SHALL have these debug inputs: DbgHalt 1 (level, halt request) and DbgStep 1 (single-cycle pulse, step request).
REQ-005 The block SHALL have these pipeline control outputs: StallF 1, StallD 1, FlushD 1, FlushE 1, ForwardAE 2, ForwardBE 2.
REQ-006 The block SHALL have these status outputs: HaltedAck 1 (core halted); StallCount 32 (load-use stall cycles); FlushCount 32 (redirect cycles).

Function
REQ-007 ForwardAE SHALL be combinational: 2'b10 if RegWriteM && RdM!=0 && RdM==Rs1E; else 2'b01 if RegWriteW && RdW!=0 && RdW==Rs1E; else 2'b00.
REQ-008 ForwardBE SHALL follow the REQ-007 rule using Rs2E; the memory stage SHALL win when both matches hold.
REQ-009 lwStall SHALL equal (ResultSrcE==2'b01) && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
REQ-010 The FSM SHALL have four states: RUN, DRAIN, HALTED, STEP; it SHALL be registered and change state only on the rising clk edge.
REQ-011 In RUN and STEP: StallF=StallD=lwStall; FlushD=PCSrcE; FlushE=lwStall|PCSrcE.
REQ-012 In DRAIN and HALTED with PCSrcE=0: StallF=StallD=1, FlushD=0, FlushE=1 (hold F/D, inject bubble into E).
REQ-013 In DRAIN and HALTED with PCSrcE=1: StallF=0, StallD=0, FlushD=1, FlushE=1, so the redirect target loads into the PC.
REQ-014 RUN transitions: if DbgHalt=1, go to DRAIN and load a 2-bit drain counter with 3; otherwise stay in RUN.
REQ-015 DRAIN: decrement the counter each cycle; at counter==1, go to HALTED; DbgHalt and DbgStep SHALL be ignored during DRAIN.
REQ-016 HALTED transitions: DbgHalt=0 -> RUN (priority over step); else DbgStep=1 -> STEP; else stay in HALTED.
REQ-017 HaltedAck SHALL be 1 only in HALTED.
REQ-018 STEP transitions: if lwStall=1, stay in STEP; otherwise go to DRAIN with counter=3; exactly one instruction SHALL issue from D to E per step.
REQ-019 StallCount SHALL increment by 1 in each cycle where the state is RUN or STEP and lwStall=1.
REQ-020 FlushCount SHALL increment by 1 in each cycle where PCSrcE=1, in any state.
REQ-021 Both counters SHALL wrap modulo 2^32 with no saturation and no overflow flag.
REQ-022 When DbgHalt and PCSrcE are both 1 in RUN in the same cycle, the REQ-011 flush SHALL apply in that cycle and the next state SHALL be DRAIN.
REQ-023 When DbgHalt=1 coincides with lwStall=1 in RUN, the stall SHALL apply in that cycle, the next state SHALL be DRAIN, and the stalled D instruction SHALL be retained.

Reset
REQ-024 While rst=1, all outputs SHALL be 0: StallF, StallD, FlushD, FlushE, HaltedAck = 0; ForwardAE = ForwardBE = 2'b00.
REQ-025 On a clk edge with rst=1, the state SHALL become RUN and the drain counter, StallCount and FlushCount SHALL become 0.
REQ-026 A reset asserted mid-DRAIN, mid-HALTED or mid-STEP SHALL take effect at the next edge, with no residual halt.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=2'b10. Then RegWriteM=0 -> ForwardAE=2'b01. Then Rs1E=0 with RdM=RdW=0 -> ForwardAE=2'b00.
- ResultSrcE=2'b01, RdE=7, Rs2D=7 for 1 cycle -> StallF=StallD=FlushE=1 and FlushD=0; StallCount 0->1.
- PCSrcE=1 for 1 cycle in RUN -> FlushD=FlushE=1 and StallF=0; FlushCount 0->1.
- DbgHalt=1 held from cycle 0 -> state is DRAIN in cycles 1-3 and HaltedAck=1 from cycle 4. DbgStep pulse -> one STEP cycle with StallD=0, three DRAIN cycles, then HaltedAck=1 again. DbgHalt=0 -> RUN next cycle.
- PCSrcE=1 in the first DRAIN cycle -> StallF=0, FlushD=FlushE=1; HALTED is still reached after 3 DRAIN cycles.
- From HALTED with StallCount=9, assert rst for 1 cycle -> RUN, HaltedAck=0, StallCount=0, FlushCount=0.
